tx_pingpong_sched: RTL and testbench
====================================

// Module: tx_pingpong_sched
// PURPOSE
//  Scheduler for the RGMII frame transmitter's 2x1024-byte ping-pong payload buffer.
//  - Writer side: accepts a payload byte stream, fills bank 0 then bank 1 alternately,
//    and drives the buffer write port.
//  - Sender side: when a bank is full, hands it to the transmitter via the idx level/toggle.
//    It then tracks the tx busy signal (txctl), releases the bank and enforces an inter-frame gap.
// PARAMETERS
//  HALF_BYTES   1024  payload bytes per bank (power of 2; one frame per bank)
//  IFG_CYCLES   12    clk125 cycles idle after txctl falls before the next idx toggle
//  START_TO     64    max cycles from idx toggle to txctl rise before timeout
//  DROP_ON_FULL 0     1: in_ready stuck high, excess bytes dropped; 0: backpressure
// PORTS
//  clk125      in   1   125 MHz clock, all logic on posedge
//  rst         in   1   synchronous active-high reset
//  in_valid    in   1   payload byte valid
//  in_data     in   8   payload byte
//  in_ready    out  1   byte accepted when in_valid & in_ready
//  buf_we      out  1   buffer write enable
//  buf_wa      out  11  buffer write address {bank, offset[9:0]}
//  buf_wd      out  8   buffer write data
//  idx         out  1   bank to transmit; every level change starts one frame
//  txctl       in   1   transmitter busy (high while frame on wire)
//  frames_sent out  16  completed frames, wraps 0xFFFF->0
//  drop_cnt    out  16  bytes dropped (DROP_ON_FULL=1 only), saturates at 0xFFFF
//  to_err      out  1   sticky: txctl did not rise within START_TO
// BEHAVIOUR
//  Reset values:
//  - all outputs 0 except idx=1 and in_ready=1, so the first frame (bank 0) is a 1->0 toggle.
//  - Both banks FREE, wbank=0, woff=0, FSM=IDLE.
//  - rst mid-frame aborts everything to these values; the buffer contents are not cleared.
//  Bank state per bank: FREE -> FULL (writer) -> SENDING (sender) -> FREE.
//  Writer:
//  - in_ready = (bank[wbank]==FREE) | DROP_ON_FULL.
//  - On accept into a FREE bank: one cycle later buf_we=1, buf_wa={wbank,woff}, buf_wd=in_data.
//  - woff increments on each accept. At woff==HALF_BYTES-1 the bank becomes FULL on the accept cycle,
//    woff wraps to 0 and wbank flips.
//  - Accept while bank[wbank]!=FREE (DROP mode): no write, drop_cnt+1.
//  Sender FSM:
//  - IDLE: if bank[sbank]==FULL -> idx<=sbank, bank->SENDING, tcnt<=0, go WAIT_START.
//    sbank starts at 0 and alternates, so idx always changes level.
//  - WAIT_START: tcnt++. If txctl=1 -> SEND. If tcnt==START_TO-1 -> to_err<=1, bank->FREE,
//    sbank flips, go GAP; frames_sent is not incremented.
//  - SEND: when txctl=0 -> bank->FREE, sbank flips, frames_sent+1, gcnt<=0, go GAP.
//  - GAP: gcnt++. When gcnt==IFG_CYCLES-1 -> IDLE.
//  - txctl is ignored in IDLE and GAP.
//  Timing:
//  - Earliest idx toggle: 1 cycle after the accept of a bank's last byte.
//    That byte's buf_we lands in the same cycle, ahead of the transmitter's ~24-byte header lead.
//  - Simultaneous events: a sender free and a writer check in the same cycle use registered state.
//    The writer sees FREE the next cycle (1-cycle in_ready stall).
//  - Both banks FULL: in_ready=0 (backpressure) until SEND completes.
//  Counters: 16-bit. frames_sent wraps modulo 2^16; drop_cnt saturates at 0xFFFF.
// TESTING
//  1. Stream 1024 bytes 0x00..0xFF repeating, tx model asserts txctl 5 cycles after the idx edge
//     for 1052 cycles -> idx goes 1->0 one cycle after the last accept; frames_sent=1;
//     bank 0 addresses 0..1023 written once each.
//  2. Stream 3072 bytes back-to-back with DROP_ON_FULL=0 -> in_ready low while both banks are busy;
//     idx sequence 0,1,0; no gap between txctl fall and idx toggle shorter than 12 cycles;
//     frames_sent=3; no byte lost.
//  3. DROP_ON_FULL=1, 3072 bytes back-to-back, tx model stalled -> drop_cnt=1024, in_ready stays 1.
//  4. Tx model never raises txctl -> to_err=1 at 64 cycles after the toggle; bank freed;
//     frames_sent=0; next full bank toggles idx to 1.
//  5. Pulse rst during SEND at byte 500 -> next cycle idx=1, counters 0, in_ready=1, FSM IDLE;
//     the next 1024 bytes produce a normal frame from bank 0.
//  6. Preload frames_sent to 0xFFFF via 65536 short-model frames -> wraps to 0x0000.

Source files
------------

// File: rtl/tx_pingpong_sched_if.sv
// Payload stream, buffer write port and transmitter handshake of the
// ping-pong TX scheduler, bundled so the scheduler and its environment share one view.
interface tx_pingpong_sched_if #(
    parameter int AW = 11
);
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic          buf_we;
    logic [AW-1:0] buf_wa;
    logic [7:0]    buf_wd;
    logic          idx;
    logic          txctl;
    logic [15:0]   frames_sent;
    logic [15:0]   drop_cnt;
    logic          to_err;

    modport master (
        output in_valid, in_data, txctl,
        input  in_ready, buf_we, buf_wa, buf_wd, idx, frames_sent, drop_cnt, to_err
    );

    modport slave (
        input  in_valid, in_data, txctl,
        output in_ready, buf_we, buf_wa, buf_wd, idx, frames_sent, drop_cnt, to_err
    );
endinterface

// File: rtl/tx_pingpong_sched.sv
// Ping-pong payload buffer scheduler for the RGMII transmitter: fills two banks
// alternately and hands each full bank over by toggling idx, then enforces the IFG.
module tx_pingpong_sched #(
    parameter int HALF_BYTES   = 1024,
    parameter int IFG_CYCLES   = 12,
    parameter int START_TO     = 64,
    parameter bit DROP_ON_FULL = 1'b0
) (
    input  logic               clk125,
    input  logic               rst,
    tx_pingpong_sched_if.slave bus
);
    // state        | meaning
    // S_IDLE       | waiting for bank[sbank] to be FULL
    // S_WAIT_START | idx toggled, waiting for txctl rise (tcnt counts down)
    // S_SEND       | frame on the wire, waiting for txctl fall
    // S_GAP        | inter-frame gap (gcnt counts down)
    localparam int OW = $clog2(HALF_BYTES);
    localparam int TW = $clog2(START_TO + 1);
    localparam int GW = $clog2(IFG_CYCLES + 1);

    typedef enum logic [1:0] {B_FREE, B_FULL, B_SENDING} bank_t;
    typedef enum logic [1:0] {S_IDLE, S_WAIT_START, S_SEND, S_GAP} state_t;

    bank_t         bank_st [2];
    state_t        state;
    logic          wbank;
    logic          sbank;
    logic [OW-1:0] woff;
    logic [TW-1:0] tcnt;
    logic [GW-1:0] gcnt;
    logic          wr_pend;
    logic [OW:0]   wr_addr;
    logic [7:0]    wr_data;
    logic          wr_free;
    logic          accept;

    assign wr_free      = (bank_st[wbank] == B_FREE);
    assign bus.in_ready = wr_free | DROP_ON_FULL;
    assign accept       = bus.in_valid & bus.in_ready;

    always_ff @(posedge clk125) begin
        if (rst) begin
            bank_st[0]      <= B_FREE;
            bank_st[1]      <= B_FREE;
            state           <= S_IDLE;
            wbank           <= 1'b0;
            sbank           <= 1'b0;
            woff            <= '0;
            tcnt            <= '0;
            gcnt            <= '0;
            wr_pend         <= 1'b0;
            wr_addr         <= '0;
            wr_data         <= '0;
            bus.buf_we      <= 1'b0;
            bus.buf_wa      <= '0;
            bus.buf_wd      <= '0;
            bus.idx         <= 1'b1;
            bus.frames_sent <= '0;
            bus.drop_cnt    <= '0;
            bus.to_err      <= 1'b0;
        end else begin
            // Two-stage write path so the last byte's write lands with the idx toggle.
            wr_pend    <= accept & wr_free;
            bus.buf_we <= wr_pend;
            bus.buf_wa <= wr_addr;
            bus.buf_wd <= wr_data;
            if (accept && wr_free) begin
                wr_addr <= {wbank, woff};
                wr_data <= bus.in_data;
                woff    <= woff + OW'(1);
                if (&woff) begin
                    bank_st[wbank] <= B_FULL;
                    wbank          <= ~wbank;
                end
            end else if (accept && bus.drop_cnt != 16'hFFFF) begin
                bus.drop_cnt <= bus.drop_cnt + 16'd1;
            end

            case (state)
                S_IDLE: begin
                    if (bank_st[sbank] == B_FULL) begin
                        bus.idx        <= sbank;
                        bank_st[sbank] <= B_SENDING;
                        tcnt           <= TW'(START_TO - 1);
                        state          <= S_WAIT_START;
                    end
                end
                S_WAIT_START: begin
                    if (bus.txctl) begin
                        state <= S_SEND;
                    end else if (tcnt == '0) begin
                        bus.to_err     <= 1'b1;
                        bank_st[sbank] <= B_FREE;
                        sbank          <= ~sbank;
                        gcnt           <= GW'(IFG_CYCLES - 1);
                        state          <= S_GAP;
                    end else begin
                        tcnt <= tcnt - TW'(1);
                    end
                end
                S_SEND: begin
                    if (!bus.txctl) begin
                        bank_st[sbank]  <= B_FREE;
                        sbank           <= ~sbank;
                        bus.frames_sent <= bus.frames_sent + 16'd1;
                        gcnt            <= GW'(IFG_CYCLES - 1);
                        state           <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (gcnt == '0) state <= S_IDLE;
                    else            gcnt  <= gcnt - GW'(1);
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tx_pingpong_sched.sv
// Randomized bench for tx_pingpong_sched: a frame-level reference model predicts
// writes, idx toggle cycles, in_ready, and the frame/drop/timeout counters.
module tb_tx_pingpong_sched;
    localparam int HALF = 1024;
    localparam int IFG  = 12;
    localparam int STO  = 64;

    logic       clk125 = 1'b0;
    logic       rst    = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data  = 8'h00;
    logic       txctl    = 1'b0;
    logic       sel      = 1'b0;

    always #4 clk125 = ~clk125;

    tx_pingpong_sched_if if_a ();
    tx_pingpong_sched_if if_b ();

    tx_pingpong_sched #(.HALF_BYTES(HALF), .IFG_CYCLES(IFG), .START_TO(STO), .DROP_ON_FULL(1'b0))
        dut_a (.clk125(clk125), .rst(rst), .bus(if_a));
    tx_pingpong_sched #(.HALF_BYTES(HALF), .IFG_CYCLES(IFG), .START_TO(STO), .DROP_ON_FULL(1'b1))
        dut_b (.clk125(clk125), .rst(rst), .bus(if_b));

    assign if_a.in_valid = in_valid & ~sel;
    assign if_a.in_data  = in_data;
    assign if_a.txctl    = txctl & ~sel;
    assign if_b.in_valid = in_valid & sel;
    assign if_b.in_data  = in_data;
    assign if_b.txctl    = txctl & sel;

    logic        o_ready, o_we, o_idx, o_toerr;
    logic [10:0] o_wa;
    logic [7:0]  o_wd;
    logic [15:0] o_frames, o_drops;
    assign o_ready  = sel ? if_b.in_ready    : if_a.in_ready;
    assign o_we     = sel ? if_b.buf_we      : if_a.buf_we;
    assign o_wa     = sel ? if_b.buf_wa      : if_a.buf_wa;
    assign o_wd     = sel ? if_b.buf_wd      : if_a.buf_wd;
    assign o_idx    = sel ? if_b.idx         : if_a.idx;
    assign o_toerr  = sel ? if_b.to_err      : if_a.to_err;
    assign o_frames = sel ? if_b.frames_sent : if_a.frames_sent;
    assign o_drops  = sel ? if_b.drop_cnt    : if_a.drop_cnt;

    typedef struct {
        int          at;
        logic [10:0] addr;
        logic [7:0]  data;
    } wr_t;

    int   n_chk = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   k, w, n_bytes, drops, n_started, stall_cnt;
    int   rate, d_min, d_max, l_min, l_max, never_pct;
    bit   drop_mode;
    int   full_edge [16];
    int   end_edge  [16];
    int   tog_edge  [16];
    int   tx_d      [16];
    int   tx_l      [16];
    bit   tmo       [16];
    bit   seen_ready, drv_valid;
    logic [7:0] drv_data;
    logic last_idx;
    wr_t  wq [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got=0x%0h expected=0x%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic bit bank_free(input int c, input int t);
        if (c < 2) return 1'b1;
        return (c - 2 < n_started) && (end_edge[c-2] < t);
    endfunction

    // Cycle on which frame n_started should toggle idx, or -1 while its bank is not yet full.
    function automatic int next_toggle();
        int t;
        if (n_started >= 16 || full_edge[n_started] < 0) return -1;
        t = full_edge[n_started] + 1;
        if (n_started > 0 && end_edge[n_started-1] + IFG + 1 > t)
            t = end_edge[n_started-1] + IFG + 1;
        return t;
    endfunction

    task automatic model_reset();
        k = 0; w = 0; drops = 0; n_started = 0; stall_cnt = 0;
        foreach (full_edge[i]) full_edge[i] = -1;
        wq.delete();
        last_idx   = 1'b1;
        seen_ready = 1'b1;
        drv_valid  = 1'b0;
        in_valid   = 1'b0;
        txctl      = 1'b0;
    endtask

    task automatic step();
        int   c, exp_t, ef, t0;
        bit   et, tog, exp_we;
        wr_t  e;
        @(posedge clk125);
        cyc++;
        @(negedge clk125);

        if (drv_valid && seen_ready) begin
            c = w / HALF;
            if (!drop_mode || bank_free(c, cyc)) begin
                e.at   = cyc;
                e.addr = 11'((c % 2) * HALF + (w % HALF));
                e.data = drv_data;
                wq.push_back(e);
                if (w % HALF == HALF - 1 && c < 16) full_edge[c] = cyc;
                w++;
            end else if (drops < 'hFFFF) begin
                drops++;
            end
            k++;
        end

        exp_we = (wq.size() > 0) && (wq[0].at == cyc - 1);
        chk("buf_we", o_we, exp_we);
        if (exp_we) begin
            if (o_we) begin
                chk("buf_wa", o_wa, wq[0].addr);
                chk("buf_wd", o_wd, wq[0].data);
            end
            void'(wq.pop_front());
        end

        exp_t = next_toggle();
        tog   = (o_idx !== last_idx);
        if (exp_t >= 0 && cyc == exp_t) chk("idx_toggle_due", tog, 1'b1);
        if (tog) begin
            chk("idx_edge", cyc, exp_t);
            chk("idx_bank", o_idx, n_started % 2);
            if (n_started < 16) begin
                tog_edge[n_started] = cyc;
                tmo[n_started]      = ($urandom_range(99) < never_pct);
                tx_d[n_started]     = $urandom_range(d_max, d_min);
                tx_l[n_started]     = $urandom_range(l_max, l_min);
                end_edge[n_started] = tmo[n_started] ? cyc + STO
                                                     : cyc + tx_d[n_started] + tx_l[n_started];
                n_started++;
            end
            last_idx = o_idx;
        end

        ef = 0; et = 1'b0;
        for (int i = 0; i < n_started; i++) begin
            if (end_edge[i] <= cyc) begin
                if (tmo[i]) et = 1'b1;
                else        ef++;
            end
        end
        chk("frames_sent", o_frames, 16'(ef));
        chk("to_err", o_toerr, et);
        chk("drop_cnt", o_drops, 16'(drops));
        chk("in_ready", o_ready, drop_mode ? 1'b1 : bank_free(w / HALF, cyc + 1));
        seen_ready = o_ready;
        if (!o_ready) stall_cnt++;

        txctl = 1'b0;
        if (n_started > 0 && !tmo[n_started-1]) begin
            t0    = tog_edge[n_started-1] + tx_d[n_started-1];
            txctl = (cyc >= t0 - 1) && (cyc <= t0 + tx_l[n_started-1] - 2);
        end
        drv_valid = (k < n_bytes) && ($urandom_range(99) < rate);
        drv_data  = 8'(k);
        in_valid  = drv_valid;
        in_data   = drv_data;
    endtask

    task automatic do_reset();
        @(negedge clk125);
        rst      = 1'b1;
        in_valid = 1'b0;
        txctl    = 1'b0;
        @(posedge clk125);
        cyc++;
        @(negedge clk125);
        rst = 1'b0;
        model_reset();
        chk("rst_idx", o_idx, 1'b1);
        chk("rst_in_ready", o_ready, 1'b1);
        chk("rst_frames", o_frames, 16'h0);
        chk("rst_drops", o_drops, 16'h0);
        chk("rst_to_err", o_toerr, 1'b0);
        chk("rst_buf_we", o_we, 1'b0);
    endtask

    task automatic run(input int nb, input bit wait_frames, input int budget);
        int start, done_at;
        bit done;
        n_bytes = nb;
        start   = cyc;
        done_at = -1;
        done    = 1'b0;
        while (!done) begin
            step();
            if (k == nb && done_at < 0) done_at = cyc;
            if (wait_frames)
                done = (done_at >= 0) && (wq.size() == 0) && (n_started == w / HALF) &&
                       (n_started == 0 || end_edge[n_started-1] + IFG + 2 <= cyc);
            else
                done = (done_at >= 0) && (cyc >= done_at + 4);
            if (!done && cyc - start > budget) begin
                chk("run_budget", cyc - start, budget);
                done = 1'b1;
            end
        end
    endtask

    task automatic cfg(input bit s, input int r, input int dmn, input int dmx,
                       input int lmn, input int lmx, input int nv);
        sel = s; drop_mode = s; rate = r;
        d_min = dmn; d_max = dmx; l_min = lmn; l_max = lmx; never_pct = nv;
    endtask

    initial begin
        cfg(1'b0, 100, 5, 5, 1052, 1052, 0);
        n_bytes = 0;
        model_reset();

        // Single frame from bank 0
        do_reset();
        run(1024, 1'b1, 20000);
        chk("t1_frames", o_frames, 16'd1);
        chk("t1_idx", o_idx, 1'b0);

        // Three frames back-to-back with backpressure
        do_reset();
        run(3072, 1'b1, 20000);
        chk("t2_frames", o_frames, 16'd3);
        chk("t2_idx", o_idx, 1'b0);
        chk("t2_stalled", stall_cnt > 0, 1'b1);

        // Drop mode with the transmitter stuck busy
        cfg(1'b1, 100, 5, 5, 50000, 50000, 0);
        do_reset();
        run(3072, 1'b0, 20000);
        chk("t3_drops", o_drops, 16'd1024);
        chk("t3_stalls", stall_cnt, 0);

        // Transmitter never starts
        cfg(1'b0, 100, 5, 5, 1052, 1052, 100);
        do_reset();
        run(2048, 1'b1, 20000);
        chk("t4_to_err", o_toerr, 1'b1);
        chk("t4_frames", o_frames, 16'd0);
        chk("t4_idx", o_idx, 1'b1);

        // Reset during SEND, then a clean frame
        cfg(1'b0, 100, 5, 5, 1052, 1052, 0);
        do_reset();
        run(1524, 1'b0, 20000);
        chk("t5_mid_idx", o_idx, 1'b0);
        do_reset();
        run(1024, 1'b1, 20000);
        chk("t5_frames", o_frames, 16'd1);
        chk("t5_idx", o_idx, 1'b0);

        // Random traffic, backpressure mode
        cfg(1'b0, 70, 1, 60, 1, 1500, 15);
        do_reset();
        run(4096, 1'b1, 40000);

        // Random traffic, drop mode
        cfg(1'b1, 80, 1, 60, 1, 2500, 15);
        do_reset();
        run(3072, 1'b1, 40000);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog at cycle %0d: got=running expected=finished", cyc);
        $fatal(1, "watchdog expired");
    end
endmodule
